rotation_line_parser: RTL



---
 rtl/rotation_line_parser.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rotation_line_parser.sv
// ASCII line parser feeding the rotation coprocessor: "L<digits>" / "R<digits>" records
// become sign-extended values, emitted as paced single-cycle strobes.
module rotation_line_parser #(
    parameter int WIDTH_DOUT    = 128,
    parameter int WIDTH_COMPUTE = 32,
    parameter int MAX_DIGITS    = 9,
    parameter int MIN_GAP       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid,
    output logic [15:0]           rec_count,
    output logic [7:0]            err_count,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_DIGITS);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        DISCARD
    } state_t;

    state_t                   state;
    logic                     dir_r;
    logic [WIDTH_COMPUTE-1:0] acc;
    logic [CNT_W-1:0]         dig_cnt;
    logic                     pending;
    logic [WIDTH_COMPUTE-1:0] pend_val;
    logic [GAP_W-1:0]         gap;

    // Byte classification
    logic is_digit, is_eol, is_blank, is_l, is_r;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign is_blank = (rx_data == 8'h20);
    assign is_l     = (rx_data == 8'h4C);
    assign is_r     = (rx_data == 8'h52);

    // acc*10 + digit as two shifts and adds
    logic [WIDTH_COMPUTE-1:0] acc_next;
    logic [WIDTH_COMPUTE-1:0] rec_value;
    assign acc_next  = (acc << 3) + (acc << 1) + {{(WIDTH_COMPUTE-4){1'b0}}, rx_data[3:0]};
    assign rec_value = dir_r ? acc : -acc;

    logic rec_done, parse_err, emit_now, overflow, err_inc;
    logic pending_next;
    logic [GAP_W-1:0] gap_next;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rec_done  = 1'b0;
        parse_err = 1'b0;
        if (rx_valid) begin
            unique case (state)
                IDLE: parse_err = !(is_l || is_r || is_eol || is_blank);
                DIGITS: begin
                    if (is_digit) begin
                        parse_err = (dig_cnt == MAX_CNT);
                    end else if (is_eol) begin
                        rec_done  = (dig_cnt != '0);
                        parse_err = (dig_cnt == '0);
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A record finishing on the emission cycle takes the slot being freed.
    always_comb begin
        emit_now = pending && (gap == '0);
        overflow = rec_done && pending && !emit_now;
        err_inc  = parse_err || overflow;

        pending_next = pending;
        if (rec_done && (!pending || emit_now))
            pending_next = 1'b1;
        else if (emit_now)
            pending_next = 1'b0;

        gap_next = gap;
        if (emit_now)
            gap_next = GAP_RELOAD;
        else if (gap != '0)
            gap_next = gap - 1'b1;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset is synchronous; it is only seen on a clock edge.
            state      <= IDLE;
            dir_r      <= 1'b0;
            acc        <= '0;
            dig_cnt    <= '0;
            pending    <= 1'b0;
            pend_val   <= '0;
            gap        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            rec_count  <= '0;
            err_count  <= '0;
            busy       <= 1'b0;
        end else begin
            dout_valid <= emit_now;
            pending    <= pending_next;
            gap        <= gap_next;
            busy       <= pending_next || (gap_next != '0);

            if (emit_now) begin
                dout      <= {{(WIDTH_DOUT-WIDTH_COMPUTE){pend_val[WIDTH_COMPUTE-1]}}, pend_val};
                rec_count <= rec_count + 16'd1;
            end

            if (rec_done && (!pending || emit_now))
                pend_val <= rec_value;

            if (err_inc && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;

            if (rx_valid) begin
                unique case (state)
                    IDLE: begin
                        if (is_l || is_r) begin
                            dir_r   <= is_r;
                            acc     <= '0;
                            dig_cnt <= '0;
                            state   <= DIGITS;
                        end else if (!(is_eol || is_blank)) begin
                            state <= DISCARD;
                        end
                    end
                    DIGITS: begin
                        if (is_digit) begin
                            if (dig_cnt == MAX_CNT) begin
                                state <= DISCARD;
                            end else begin
                                acc     <= acc_next;
                                dig_cnt <= dig_cnt + 1'b1;
                            end
                        end else if (is_eol) begin
                            state <= IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (is_eol)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
